// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the five-stage MIPS pipeline: vectors, idle encodings,
// exception codes and the Tnew saturating-decrement helper.
package cpu_pipe_pkg;

    localparam logic [31:0] EXC_VECTOR    = 32'h0000_4180;
    localparam logic [31:0] RESET_VECTOR  = 32'h0000_3000;
    localparam logic [3:0]  MEMWRITE_IDLE = 4'd10;

    localparam int unsigned TNEW_W     = 3;
    localparam int unsigned EXC_CODE_W = 5;
    localparam int unsigned PC_W       = 32;

    typedef enum logic [EXC_CODE_W-1:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Tnew counts down one per cycle and bottoms out at zero.
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] tnew);
        return (tnew != '0) ? tnew - TNEW_W'(1) : '0;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with hold, bubble and exception flush,
// plus saturating bubble/hold statistics.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 160,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       TNEW_W     = 3,
    parameter logic [31:0]       RESET_PC   = RESET_VECTOR,
    parameter logic [31:0]       EXC_PC     = EXC_VECTOR,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic              clear_all,
    input  logic              valid_in,
    input  logic [31:0]       pc_in,
    input  logic [DATA_W-1:0] payload_in,
    input  logic [TNEW_W-1:0] tnew_in,
    input  logic              exc_flag_in,
    input  logic [4:0]        exc_code_in,
    input  logic              delay_in,
    output logic              valid_out,
    output logic [31:0]       pc_out,
    output logic [DATA_W-1:0] payload_out,
    output logic [TNEW_W-1:0] tnew_out,
    output logic              exc_flag_out,
    output logic [4:0]        exc_code_out,
    output logic              delay_out,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  hold_cnt
);

    logic bubble_inc_c;
    logic hold_inc_c;

    // Statistics events follow the same priority as the data path.
    always_comb begin
        bubble_inc_c = 1'b0;
        hold_inc_c   = 1'b0;
        if (!clear_all) begin
            if (clear) begin
                bubble_inc_c = 1'b1;
            end else if (!en) begin
                hold_inc_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out    <= 1'b0;
            pc_out       <= RESET_PC;
            payload_out  <= BUBBLE_VAL;
            tnew_out     <= '0;
            exc_flag_out <= 1'b0;
            exc_code_out <= '0;
            delay_out    <= 1'b0;
        end else if (clear_all) begin
            valid_out    <= 1'b0;
            pc_out       <= EXC_PC;
            payload_out  <= BUBBLE_VAL;
            tnew_out     <= '0;
            exc_flag_out <= 1'b0;
            exc_code_out <= '0;
            delay_out    <= 1'b0;
        end else if (clear) begin
            // Bubble keeps PC and delay flag so a later EPC still points right.
            valid_out    <= 1'b0;
            pc_out       <= pc_in;
            payload_out  <= BUBBLE_VAL;
            tnew_out     <= '0;
            exc_flag_out <= 1'b0;
            exc_code_out <= '0;
            delay_out    <= delay_in;
        end else if (!en) begin
            // The stage keeps computing while stalled, so Tnew still drains.
            tnew_out <= (tnew_out != '0) ? tnew_out - TNEW_W'(1) : '0;
        end else begin
            valid_out    <= valid_in;
            pc_out       <= pc_in;
            payload_out  <= payload_in;
            tnew_out     <= (tnew_in != '0) ? tnew_in - TNEW_W'(1) : '0;
            exc_flag_out <= exc_flag_in;
            exc_code_out <= exc_code_in;
            delay_out    <= delay_in;
        end
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc_c),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hold_inc_c),
        .count (hold_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: load, hold, bubble, flush, reset and
// counter saturation, with hand-computed expectations.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 160;
    localparam int unsigned TNEW_W = 3;
    localparam int unsigned CNT_W  = 16;
    localparam logic [DATA_W-1:0] BUBBLE = 160'hA;

    logic              clk = 1'b0;
    logic              reset, en, clear, clear_all, valid_in;
    logic [31:0]       pc_in;
    logic [DATA_W-1:0] payload_in;
    logic [TNEW_W-1:0] tnew_in;
    logic              exc_flag_in;
    logic [4:0]        exc_code_in;
    logic              delay_in;
    logic              valid_out;
    logic [31:0]       pc_out;
    logic [DATA_W-1:0] payload_out;
    logic [TNEW_W-1:0] tnew_out;
    logic              exc_flag_out;
    logic [4:0]        exc_code_out;
    logic              delay_out;
    logic [CNT_W-1:0]  bubble_cnt, hold_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_reg #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE),
        .TNEW_W     (TNEW_W),
        .RESET_PC   (32'h0000_3000),
        .EXC_PC     (32'h0000_4180),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .clear        (clear),
        .clear_all    (clear_all),
        .valid_in     (valid_in),
        .pc_in        (pc_in),
        .payload_in   (payload_in),
        .tnew_in      (tnew_in),
        .exc_flag_in  (exc_flag_in),
        .exc_code_in  (exc_code_in),
        .delay_in     (delay_in),
        .valid_out    (valid_out),
        .pc_out       (pc_out),
        .payload_out  (payload_out),
        .tnew_out     (tnew_out),
        .exc_flag_out (exc_flag_out),
        .exc_code_out (exc_code_out),
        .delay_out    (delay_out),
        .bubble_cnt   (bubble_cnt),
        .hold_cnt     (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [31:0] pc,
                               input logic [DATA_W-1:0] pl, input logic [TNEW_W-1:0] tn,
                               input logic ef, input logic [4:0] ec, input logic dl);
        check({tag, ".valid"},    DATA_W'(valid_out),    DATA_W'(v));
        check({tag, ".pc"},       DATA_W'(pc_out),       DATA_W'(pc));
        check({tag, ".payload"},  payload_out,           pl);
        check({tag, ".tnew"},     DATA_W'(tnew_out),     DATA_W'(tn));
        check({tag, ".exc_flag"}, DATA_W'(exc_flag_out), DATA_W'(ef));
        check({tag, ".exc_code"}, DATA_W'(exc_code_out), DATA_W'(ec));
        check({tag, ".delay"},    DATA_W'(delay_out),    DATA_W'(dl));
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] h);
        check({tag, ".bubble_cnt"}, DATA_W'(bubble_cnt), DATA_W'(b));
        check({tag, ".hold_cnt"},   DATA_W'(hold_cnt),   DATA_W'(h));
    endtask

    initial begin
        logic [DATA_W-1:0] pl_a;
        pl_a = 160'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_1111_2222_3333;

        reset = 1'b1; en = 1'b0; clear = 1'b0; clear_all = 1'b0; valid_in = 1'b0;
        pc_in = 32'h0; payload_in = '0; tnew_in = '0; exc_flag_in = 1'b0;
        exc_code_in = 5'd0; delay_in = 1'b0;
        #1;
        tick();
        check_state("reset", 1'b0, 32'h3000, BUBBLE, 3'd0, 1'b0, 5'd0, 1'b0);
        check_cnt("reset", 16'd0, 16'd0);

        // Three loads with tnew_in=2
        reset = 1'b0; en = 1'b1; valid_in = 1'b1; tnew_in = 3'd2;
        for (int i = 0; i < 3; i++) begin
            pc_in      = 32'h3000 + 32'(4 * i);
            payload_in = 160'h1111 + 160'(i);
            delay_in   = (i == 1);
            tick();
            check_state($sformatf("load%0d", i), 1'b1, 32'h3000 + 32'(4 * i),
                        160'h1111 + 160'(i), 3'd1, 1'b0, 5'd0, (i == 1));
        end

        // Load tnew_in=3 then stall three cycles
        pc_in = 32'h300C; payload_in = pl_a; tnew_in = 3'd3; delay_in = 1'b0;
        tick();
        check("load_t3.tnew", DATA_W'(tnew_out), DATA_W'(3'd2));
        en = 1'b0; pc_in = 32'h9999; payload_in = '1; tnew_in = 3'd7; valid_in = 1'b0;
        tick(); check("hold1.tnew", DATA_W'(tnew_out), DATA_W'(3'd1));
        tick(); check("hold2.tnew", DATA_W'(tnew_out), DATA_W'(3'd0));
        tick();
        check_state("hold3", 1'b1, 32'h300C, pl_a, 3'd0, 1'b0, 5'd0, 1'b0);
        check_cnt("hold3", 16'd0, 16'd3);

        // Bubble keeps pc/delay, drops exception
        en = 1'b1; clear = 1'b1; valid_in = 1'b1; pc_in = 32'h3010; delay_in = 1'b1;
        exc_flag_in = 1'b1; exc_code_in = 5'd4; tnew_in = 3'd5;
        tick();
        check_state("clear", 1'b0, 32'h3010, BUBBLE, 3'd0, 1'b0, 5'd0, 1'b1);
        check_cnt("clear", 16'd1, 16'd3);

        // Clear wins over en=0 and is not a hold
        en = 1'b0; pc_in = 32'h3014; delay_in = 1'b0;
        tick();
        check_state("clear_en0", 1'b0, 32'h3014, BUBBLE, 3'd0, 1'b0, 5'd0, 1'b0);
        check_cnt("clear_en0", 16'd2, 16'd3);

        // Flush with everything asserted: vector PC, counters untouched
        clear_all = 1'b1; pc_in = 32'h3018; delay_in = 1'b1;
        tick();
        check_state("clear_all", 1'b0, 32'h4180, BUBBLE, 3'd0, 1'b0, 5'd0, 1'b0);
        check_cnt("clear_all", 16'd2, 16'd3);

        // Load carrying an overflow exception, tnew_in=0 stays 0
        clear_all = 1'b0; clear = 1'b0; en = 1'b1; valid_in = 1'b1;
        pc_in = 32'h3020; payload_in = 160'h55; tnew_in = 3'd0;
        exc_flag_in = 1'b1; exc_code_in = 5'd12; delay_in = 1'b0;
        tick();
        check_state("load_exc", 1'b1, 32'h3020, 160'h55, 3'd0, 1'b1, 5'd12, 1'b0);

        // Max tnew gives max-1, then one hold drains it by one
        tnew_in = 3'd7; valid_in = 1'b0; exc_flag_in = 1'b0; exc_code_in = 5'd0;
        payload_in = 160'h77;
        tick();
        check("load_tmax.tnew", DATA_W'(tnew_out), DATA_W'(3'd6));
        check("load_tmax.valid", DATA_W'(valid_out), DATA_W'(1'b0));
        check("load_tmax.payload", payload_out, 160'h77);
        en = 1'b0;
        tick();
        check("hold_tmax.tnew", DATA_W'(tnew_out), DATA_W'(3'd5));
        check_cnt("hold_tmax", 16'd2, 16'd4);

        // Reset in the middle of a stall and flush
        reset = 1'b1; clear_all = 1'b1;
        tick();
        check_state("reset_mid", 1'b0, 32'h3000, BUBBLE, 3'd0, 1'b0, 5'd0, 1'b0);
        check_cnt("reset_mid", 16'd0, 16'd0);

        // Long stall saturates hold_cnt
        reset = 1'b0; clear_all = 1'b0; en = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        check_cnt("sat_reach", 16'd0, 16'hFFFF);
        tick();
        tick();
        check_cnt("sat_stick", 16'd0, 16'hFFFF);
        check("sat_stick.pc", DATA_W'(pc_out), DATA_W'(32'h3000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the five-stage MIPS CPU. It replaces the hand-written per-stage latches: one instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries PC, an opaque control/data payload, the Tnew countdown, exception flag/code, the delay-slot flag and a valid bit.
- Supports hold (stall), bubble insertion, and exception flush-to-vector.
- Also tracks per-stage bubble and hold statistics.

Parameters:
DATA_W, 160, width of opaque payload bus (imm, RD1, RD2, control fields concatenated by instantiator)
BUBBLE_VAL, 160'h0, payload value loaded on reset/clear/clear_all (lets MemWrite-style fields idle at nonzero codes, e.g. 4'd10)
TNEW_W, 3, width of Tnew field
RESET_PC, 32'h0000_3000, pc_out after reset
EXC_PC, 32'h0000_4180, pc_out after clear_all
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; highest priority
en  input  1  1 = load new contents, 0 = hold (stall)
clear  input  1  insert bubble, keep PC/delay flag
clear_all  input  1  exception/eret flush, PC forced to EXC_PC
valid_in  input  1  upstream slot holds a real instruction
pc_in  input  32  instruction PC
payload_in  input  DATA_W  control/data fields
tnew_in  input  TNEW_W  cycles until result available, as seen upstream
exc_flag_in  input  1  exception already detected upstream
exc_code_in  input  5  ExcCode of that exception
delay_in  input  1  instruction is in a branch delay slot
valid_out, pc_out, payload_out, tnew_out, exc_flag_out, exc_code_out, delay_out  output  widths as inputs  registered copies
bubble_cnt  output  CNT_W  cycles a bubble was inserted by clear
hold_cnt  output  CNT_W  cycles held with en=0

Behaviour:
- Single always block on posedge clk. Priority: reset > clear_all > clear > !en (hold) > load.
- Reset values:
  - valid_out=0, pc_out=RESET_PC, payload_out=BUBBLE_VAL.
  - tnew_out=0, exc_flag_out=0, exc_code_out=0, delay_out=0.
  - bubble_cnt=0, hold_cnt=0.
- clear_all: valid_out=0, pc_out=EXC_PC, payload_out=BUBBLE_VAL, tnew_out=0, exc_flag_out=0, exc_code_out=0, delay_out=0. Counters unchanged.
- clear: bubble state.
  - valid_out=0, payload_out=BUBBLE_VAL, tnew_out=0, exc_flag/code=0.
  - pc_out=pc_in and delay_out=delay_in, so EPC of a later exception remains correct.
  - bubble_cnt+1. clear overrides en=0: clear with en=0 still bubbles and does not count as a hold.
- Hold (en=0, no clear):
  - All fields keep their value.
  - tnew_out saturating-decrements (tnew_out!=0 ? tnew_out-1 : 0), because the stage keeps computing while stalled.
  - hold_cnt+1.
- Load (en=1):
  - All fields copy their inputs.
  - tnew_out = (tnew_in!=0) ? tnew_in-1 : 0. Never wraps below 0; tnew_in at max value gives max-1.
  - valid_out=valid_in.
  - If valid_in=0, payload still copies as-is; upstream is responsible for bubble encoding.
- Counters saturate at all-ones and never wrap. They reset only on reset.
- Latency: exactly 1 cycle input to output. No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush: reset values win on that edge. The next cycle follows the normal priority.

Decomposition:
- Package cpu_pipe_pkg holds:
  - EXC_VECTOR=32'h4180, RESET_VECTOR=32'h3000, MEMWRITE_IDLE=4'd10.
  - ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
  - TNEW_W, and a helper function sat_dec(tnew).
- No sub-module needed. The two saturating counters may share a small sat_counter sub-module (increment enable, synchronous clear, saturate at max).

Test Plan:
- Reset then 3 loads with pc_in=0x3000/0x3004/0x3008, tnew_in=2 -> after each edge pc_out tracks input, tnew_out=1, valid_out=1; before the first load pc_out=0x3000, payload_out=BUBBLE_VAL.
- en=0 for 3 cycles after loading tnew_in=3 (tnew_out=2) -> tnew_out 1,0,0; pc/payload unchanged; hold_cnt=3.
- clear with pc_in=0x3010, delay_in=1, exc_flag_in=1 -> pc_out=0x3010, delay_out=1, exc_flag_out=0, valid_out=0, payload_out=BUBBLE_VAL, bubble_cnt+1.
- clear_all and clear and en=0 asserted together -> pc_out=0x4180, all flags 0, neither counter changes.
- Load with exc_flag_in=1, exc_code_in=12 -> exc_flag_out=1, exc_code_out=12 next cycle; then reset with en=0 -> all reset values, counters 0.
- Force hold_cnt to 16'hFFFF via long stall -> stays 16'hFFFF on further holds.
